// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main sequencing FSM for the multicycle ARM datapath. It steps each
// instruction through FETCH / DECODE / execute / writeback. In each state it
// drives the datapath mux selects and the raw write strobes. It also
// handshakes with a shared instruction/data memory that may insert wait
// states, and aborts an access that waits too long.
//
// Parameters
//   WAIT_LIMIT  max consecutive wait cycles in a memory state before the
//               access is aborted (0 disables the timeout, range 0..255)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   op           instr[27:26]
//   funct        instr[25:20] (funct[5]=I, funct[0]=L for memory ops)
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   ir_write     load instruction register
//   next_pc      PC <= PC+4
//   adr_src      memory address select: 0=PC, 1=ALU result register
//   alu_src_a    0=Rn, 1=PC
//   alu_src_b    0=Rm, 1=ExtImm, 2=const 4
//   result_src   0=ALUOut, 1=Data reg, 2=ALU direct
//   alu_op       1=ALU function from funct, 0=add
//   reg_w        raw register write strobe (gated later by condex)
//   mem_w        raw memory write strobe (gated later by condex)
//   branch       raw branch strobe (gated later by condex)
//   instr_done   one-cycle pulse on the final cycle of an instruction
//   illegal      one-cycle pulse when op=2'b11 is decoded
//   mem_timeout  one-cycle pulse when a wait-state abort happens
//   state        current state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    localparam logic [7:0] LIMIT  = 8'(WAIT_LIMIT);
    localparam bit         TMO_EN = (WAIT_LIMIT != 0);

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic [7:0] r_wait_cnt;
    logic       w_in_mem_state;
    logic       w_waiting;
    logic       w_timeout;

    // Only funct[5] (I) and funct[0] (L) steer sequencing. The rest of funct
    // belongs to the ALU decoder.
    logic w_unused_funct;
    assign w_unused_funct = ^funct[4:1];

    assign w_in_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                            (r_state == S_MEMWRITE);
    assign w_waiting      = w_in_mem_state && !mem_ready;
    // A completing access (mem_ready=1) wins over the limit, because
    // w_waiting already requires mem_ready=0.
    assign w_timeout      = TMO_EN && w_waiting && (r_wait_cnt == LIMIT);

    // -----------------------------------------------------------------------
    // State register and wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            // The counter restarts on any state change. It also restarts
            // after an abort, which matters when FETCH times out back into
            // FETCH.
            if ((w_state_next != r_state) || w_timeout) begin
                r_wait_cnt <= 8'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    2'b00:   w_state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: w_state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_state_next = S_ALUWB;
            S_EXECI:    w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BRANCH:   w_state_next = S_FETCH;
            default:    w_state_next = S_FETCH;
        endcase
        if (w_timeout) begin
            w_state_next = S_FETCH;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (Moore, except the mem_ready/op-qualified strobes)
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req     = 1'b0;
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        result_src  = 2'd0;
        alu_op      = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        state       = r_state;

        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
            end
            S_DECODE: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                if (op == 2'b11) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_b = 2'd1;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                alu_op = 1'b1;
            end
            S_EXECI: begin
                alu_src_b = 2'd1;
                alu_op    = 1'b1;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // An aborted access must not load IR, bump PC or write anything.
        if (w_timeout) begin
            mem_req     = 1'b0;
            mem_w       = 1'b0;
            ir_write    = 1'b0;
            next_pc     = 1'b0;
            reg_w       = 1'b0;
            mem_timeout = 1'b1;
        end

        // During reset, present a quiet FETCH. This covers the case where
        // reset abandons an instruction partway through.
        if (reset) begin
            mem_req     = 1'b0;
            ir_write    = 1'b0;
            next_pc     = 1'b0;
            reg_w       = 1'b0;
            mem_w       = 1'b0;
            branch      = 1'b0;
            instr_done  = 1'b0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
            adr_src     = 1'b0;
            alu_src_a   = 2'd1;
            alu_src_b   = 2'd2;
            result_src  = 2'd2;
            alu_op      = 1'b0;
            state       = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic       mem_ready = 1'b1;
    logic       mem_req, ir_write, next_pc, adr_src, alu_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       reg_w, mem_w, branch, instr_done, illegal, mem_timeout;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.WAIT_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_write(ir_write), .next_pc(next_pc),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .reg_w(reg_w), .mem_w(mem_w),
        .branch(branch), .instr_done(instr_done), .illegal(illegal),
        .mem_timeout(mem_timeout), .state(state)
    );

    // mux  = {adr_src, alu_src_a[1:0], alu_src_b[1:0], result_src[1:0]}
    // stb  = {mem_req, ir_write, next_pc, alu_op, reg_w, mem_w, branch,
    //         instr_done, illegal, mem_timeout}
    typedef struct packed {
        logic [3:0] st;
        logic [6:0] mux;
        logic [9:0] stb;
    } out_t;

    typedef struct {
        logic       rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam logic [6:0] M_FE = 7'b0_01_10_10;  // FETCH / DECODE
    localparam logic [6:0] M_MA = 7'b0_00_01_00;  // MEMADR / EXECI
    localparam logic [6:0] M_MR = 7'b1_00_00_00;  // MEMREAD / MEMWRITE
    localparam logic [6:0] M_WB = 7'b0_00_00_01;  // MEMWB
    localparam logic [6:0] M_Z  = 7'b0_00_00_00;  // EXECR / ALUWB
    localparam logic [6:0] M_BR = 7'b0_00_01_10;  // BRANCH

    localparam logic [5:0] F_ADD = 6'b001000;
    localparam logic [5:0] F_ADI = 6'b101000;
    localparam logic [5:0] F_LDR = 6'b000001;
    localparam logic [5:0] F_STR = 6'b000000;

    vec_t vecs[$];
    out_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic out_t actual();
        out_t a;
        a.st  = state;
        a.mux = {adr_src, alu_src_a, alu_src_b, result_src};
        a.stb = {mem_req, ir_write, next_pc, alu_op, reg_w, mem_w, branch,
                 instr_done, illegal, mem_timeout};
        return a;
    endfunction

    task automatic add(input logic rst, input logic [1:0] o, input logic [5:0] f,
                       input logic rdy, input logic [3:0] st, input logic [6:0] mux,
                       input logic [9:0] stb);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.rdy = rdy;
        v.exp.st = st; v.exp.mux = mux; v.exp.stb = stb;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs, queues its expectation, and checks it
    // mid-cycle. On return we are #1 after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        out_t e, a;
        reset = v.rst; op = v.op; funct = v.funct; mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        @(negedge clk);
        a = actual();
        e = exp_q.pop_front();
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got state=%0d mux=%b stb=%b, required state=%0d mux=%b stb=%b",
                      tag, a.st, a.mux, a.stb, e.st, e.mux, e.stb);
        $display("cyc %-10s rst=%b op=%b f=%b rdy=%b -> state=%0d stb=%b",
                 tag, v.rst, v.op, v.funct, v.rdy, a.st, a.stb);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rst, input logic [1:0] o, input logic [5:0] f,
                        input logic rdy, input logic [3:0] st, input logic [6:0] mux,
                        input logic [9:0] stb, input string tag);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.rdy = rdy;
        v.exp.st = st; v.exp.mux = mux; v.exp.stb = stb;
        apply(v, tag);
    endtask

    // Runs one instruction from FETCH with no wait states and counts cycles
    // up to and including the instr_done cycle.
    task automatic latency(input logic [1:0] o, input logic [5:0] f, input int want,
                           input string tag);
        int cyc;
        int req;
        bit seen;
        cyc = 0;
        seen = 0;
        reset = 1'b0; op = o; funct = f; mem_ready = 1'b1;
        lat_q.push_back(want);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (instr_done) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        req = lat_q.pop_front();
        checks++;
        if (seen && cyc == req) passes++;
        else $display("FAIL lat_%s: got %0d cycles (done seen=%0d), required %0d",
                      tag, cyc, seen, req);
        $display("lat %-8s cycles=%0d", tag, cyc);
    endtask

    initial begin
        // Reset, then ADD reg: 0,1,6,8
        add(1, 2'b00, F_ADD, 1, 4'd0, M_FE, 10'b0000000000);
        add(1, 2'b00, F_ADD, 1, 4'd0, M_FE, 10'b0000000000);
        add(0, 2'b00, F_ADD, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b00, F_ADD, 1, 4'd1, M_FE, 10'b0000000000);
        add(0, 2'b00, F_ADD, 1, 4'd6, M_Z,  10'b0001000000);
        add(0, 2'b00, F_ADD, 1, 4'd8, M_Z,  10'b0000100100);
        // LDR with 3 wait cycles; the 4th MEMREAD cycle hits the limit with
        // mem_ready=1, which completes normally.
        add(0, 2'b01, F_LDR, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b01, F_LDR, 1, 4'd1, M_FE, 10'b0000000000);
        add(0, 2'b01, F_LDR, 1, 4'd2, M_MA, 10'b0000000000);
        add(0, 2'b01, F_LDR, 0, 4'd3, M_MR, 10'b1000000000);
        add(0, 2'b01, F_LDR, 0, 4'd3, M_MR, 10'b1000000000);
        add(0, 2'b01, F_LDR, 0, 4'd3, M_MR, 10'b1000000000);
        add(0, 2'b01, F_LDR, 1, 4'd3, M_MR, 10'b1000000000);
        add(0, 2'b01, F_LDR, 1, 4'd4, M_WB, 10'b0000100100);
        // STR, no waits
        add(0, 2'b01, F_STR, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b01, F_STR, 1, 4'd1, M_FE, 10'b0000000000);
        add(0, 2'b01, F_STR, 1, 4'd2, M_MA, 10'b0000000000);
        add(0, 2'b01, F_STR, 1, 4'd5, M_MR, 10'b1000010100);
        // B
        add(0, 2'b10, F_STR, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b10, F_STR, 1, 4'd1, M_FE, 10'b0000000000);
        add(0, 2'b10, F_STR, 1, 4'd9, M_BR, 10'b0000001100);
        // ADD immediate
        add(0, 2'b00, F_ADI, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b00, F_ADI, 1, 4'd1, M_FE, 10'b0000000000);
        add(0, 2'b00, F_ADI, 1, 4'd7, M_MA, 10'b0001000000);
        add(0, 2'b00, F_ADI, 1, 4'd8, M_Z,  10'b0000100100);
        // Illegal op
        add(0, 2'b11, F_STR, 1, 4'd0, M_FE, 10'b1110000000);
        add(0, 2'b11, F_STR, 1, 4'd1, M_FE, 10'b0000000110);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Zero-wait latencies
        latency(2'b00, F_ADD, 4, "dp");
        latency(2'b01, F_LDR, 5, "ldr");
        latency(2'b01, F_STR, 4, "str");
        latency(2'b10, F_STR, 3, "b");
        latency(2'b11, F_STR, 2, "illegal");

        // FETCH timeout, repeated: abort on every 4th cycle, and state stays 0
        for (int k = 0; k < 2; k++) begin
            step(0, 2'b00, F_ADD, 0, 4'd0, M_FE, 10'b1000000000, "ftw0");
            step(0, 2'b00, F_ADD, 0, 4'd0, M_FE, 10'b1000000000, "ftw1");
            step(0, 2'b00, F_ADD, 0, 4'd0, M_FE, 10'b1000000000, "ftw2");
            step(0, 2'b00, F_ADD, 0, 4'd0, M_FE, 10'b0000000001, "ftmo");
        end

        // MEMWRITE timeout: mem_w held while waiting, then dropped on abort
        step(0, 2'b01, F_STR, 1, 4'd0, M_FE, 10'b1110000000, "mw_fetch");
        step(0, 2'b01, F_STR, 1, 4'd1, M_FE, 10'b0000000000, "mw_dec");
        step(0, 2'b01, F_STR, 1, 4'd2, M_MA, 10'b0000000000, "mw_adr");
        step(0, 2'b01, F_STR, 0, 4'd5, M_MR, 10'b1000010000, "mw_w0");
        step(0, 2'b01, F_STR, 0, 4'd5, M_MR, 10'b1000010000, "mw_w1");
        step(0, 2'b01, F_STR, 0, 4'd5, M_MR, 10'b1000010000, "mw_w2");
        step(0, 2'b01, F_STR, 0, 4'd5, M_MR, 10'b0000000001, "mw_tmo");
        step(0, 2'b01, F_STR, 1, 4'd0, M_FE, 10'b1110000000, "mw_back");

        // Reset during a MEMWRITE wait
        step(0, 2'b01, F_STR, 1, 4'd1, M_FE, 10'b0000000000, "rs_dec");
        step(0, 2'b01, F_STR, 1, 4'd2, M_MA, 10'b0000000000, "rs_adr");
        step(0, 2'b01, F_STR, 0, 4'd5, M_MR, 10'b1000010000, "rs_wait");
        step(1, 2'b01, F_STR, 0, 4'd0, M_FE, 10'b0000000000, "rs_rst");
        step(0, 2'b01, F_STR, 1, 4'd0, M_FE, 10'b1110000000, "rs_fetch");
        step(0, 2'b01, F_STR, 1, 4'd1, M_FE, 10'b0000000000, "rs_dec2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main sequencing FSM for the multicycle ARM datapath, replacing the single-cycle decoder timing.
- Steps each instruction through FETCH / DECODE / execute / writeback states and drives the datapath mux selects and write strobes.
- Handshakes with a shared instruction/data memory that may insert wait states, with a wait-state timeout.
- Condition gating (condex) and ALU-function decode remain in the existing conditional logic and ALU decoder; this block supplies the raw RegW/MemW/Branch/ALUOp strobes to them.

Parameters:
- WAIT_LIMIT, 15, max consecutive wait cycles tolerated in a memory state before abort; 0 disables the timeout; legal range 0..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- op  in  2  instr[27:26] from instruction register
- funct  in  6  instr[25:20]; funct[5]=I, funct[0]=L for memory ops
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- ir_write  out  1  load instruction register
- next_pc  out  1  PC update with PC+4
- adr_src  out  1  0=PC, 1=ALU result register
- alu_src_a  out  2  0=Rn, 1=PC
- alu_src_b  out  2  0=Rm, 1=ExtImm, 2=const 4
- result_src  out  2  0=ALUOut, 1=Data reg, 2=ALU direct
- alu_op  out  1  1=ALU function from funct, 0=add
- reg_w  out  1  raw register write strobe
- mem_w  out  1  raw memory write strobe
- branch  out  1  raw branch strobe
- instr_done  out  1  one-cycle pulse on final cycle of an instruction
- illegal  out  1  one-cycle pulse when op=2'b11 is decoded
- mem_timeout  out  1  one-cycle pulse on wait-state abort
- state  out  4  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10..15 return to FETCH on the next edge with no strobes.
- Outputs are decoded from state (Moore), except strobes explicitly gated by mem_ready. Unlisted outputs are 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=2, result_src=2. ir_write=next_pc=1 only when mem_ready=1. Advance to DECODE when mem_ready=1, else hold.
- DECODE: alu_src_a=1, alu_src_b=2, result_src=2. Next state:
  - op=00 with funct[5]=1 -> EXECI
  - op=00 with funct[5]=0 -> EXECR
  - op=01 -> MEMADR
  - op=10 -> BRANCH
  - op=11 -> FETCH, with illegal=1 and instr_done=1.
- MEMADR: alu_src_a=0, alu_src_b=1. Go to MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Advance to MEMWB on mem_ready, else hold.
- MEMWB: result_src=1, reg_w=1, instr_done=1. Then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_w=1 held while waiting. instr_done=1 and go to FETCH on mem_ready.
- EXECR: alu_src_a=0, alu_src_b=0, alu_op=1. EXECI: alu_src_a=0, alu_src_b=1, alu_op=1. Both go to ALUWB.
- ALUWB: result_src=0, reg_w=1, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=0, alu_src_b=1, result_src=2, branch=1, instr_done=1. Then FETCH.
- Wait counter (8-bit):
  - Clears on every state change and on reset.
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - If WAIT_LIMIT!=0 and counter==WAIT_LIMIT with mem_ready=0: mem_timeout=1, and mem_req, mem_w, ir_write, next_pc, reg_w forced 0 that cycle. Next state is FETCH, counter cleared.
  - mem_ready=1 in the same cycle as the limit takes priority (normal completion, no timeout).
- Reset:
  - While reset=1: state=FETCH (next edge), counter=0.
  - All strobes (mem_req, ir_write, next_pc, reg_w, mem_w, branch, instr_done, illegal, mem_timeout) forced 0.
  - Mux selects show FETCH values: adr_src=0, alu_src_a=1, alu_src_b=2, result_src=2, alu_op=0. state=0.
  - Reset mid-instruction abandons it; no writeback strobe fires.
- Latency with zero wait states: data-processing=4 cycles, LDR=5, STR=4, B=3, illegal=2.

Test Plan:
- Reset held 2 cycles then released, mem_ready=1, op=00 funct=6'b001000 (ADD reg) -> states 0,1,6,8,0. reg_w=1 and instr_done=1 only in ALUWB. alu_op=1 in EXECR.
- op=01 funct[0]=1 (LDR), mem_ready low 3 cycles in MEMREAD -> 0,1,2,3,3,3,3,4,0. result_src=1 and reg_w=1 in MEMWB. 8 cycles total.
- op=01 funct[0]=0 (STR), mem_ready=1 -> mem_w=1 and mem_req=1 for exactly one cycle in state 5. instr_done is coincident with it. 4 cycles.
- op=10 (B) -> 0,1,9,0. branch=1 with alu_src_b=1 in BRANCH. next_pc=1 only in FETCH.
- WAIT_LIMIT=3, mem_ready=0 forever in FETCH -> mem_timeout pulses every 4th cycle. ir_write never asserts. state stays 0.
- op=11 -> illegal and instr_done pulse in DECODE, return to FETCH. Separately, assert reset during MEMWRITE wait -> mem_w drops immediately, state=0 next edge.
